// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA burst streamer and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a; the stream structs carry valid/ready/finish for wrappers.
package dma_pkg;

    // AXI bursts must not cross a 4 KB address page.
    localparam int AXI_4KB    = 4096;
    localparam int DMA_ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } e_streamer_st_t;

    // Request side of the stream channel, so a wrapper can bundle the flat ports.
    typedef struct packed {
        logic                  valid;
        logic [DMA_ADDR_W-1:0] addr;
        logic [7:0]            alen;
        logic [2:0]            size;
    } s_dma_stream_req_t;

    // Response side of the stream channel.
    typedef struct packed {
        logic ready;
        logic finish;
    } s_dma_stream_resp_t;

endpackage

// File: rtl/dma_burst_calc.sv
// Beat count of the next INCR burst: min(remaining, MAX_BEATS, beats left in the 4 KB page).
// Latency: purely combinational.
// Backpressure: none; the caller holds its inputs stable while a request stalls.
// Ports: i_page_off  - low 12 address bits of the current burst start (bus aligned)
//        i_rem_beats - beats still to be issued
//        o_beats     - beats in the next burst (LEN_W+1 bits), o_alen - o_beats-1
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int LEN_W      = 32,
    parameter int DATA_BYTES = 8,
    parameter int MAX_BEATS  = 16
) (
    input  logic [11:0]      i_page_off,
    input  logic [LEN_W-1:0] i_rem_beats,
    output logic [LEN_W:0]   o_beats,
    output logic [7:0]       o_alen
);

    localparam int SZ = $clog2(DATA_BYTES);

    logic [LEN_W:0] w_page_bytes;
    logic [LEN_W:0] w_page_beats;
    logic [LEN_W:0] w_rem;
    logic [LEN_W:0] w_max;
    logic [LEN_W:0] w_min_rem_max;

    // The start address is bus aligned, so the shift is an exact division.
    assign w_page_bytes  = (LEN_W+1)'(AXI_4KB) - (LEN_W+1)'(i_page_off);
    assign w_page_beats  = w_page_bytes >> SZ;
    assign w_rem         = {1'b0, i_rem_beats};
    assign w_max         = (LEN_W+1)'(MAX_BEATS);
    assign w_min_rem_max = (w_rem < w_max) ? w_rem : w_max;
    assign o_beats       = (w_min_rem_max < w_page_beats) ? w_min_rem_max : w_page_beats;
    assign o_alen        = 8'(o_beats - (LEN_W+1)'(1));

endmodule

// File: rtl/dma_burst_streamer.sv
// Splits a (start address, byte length) descriptor into AXI INCR burst requests, capped at
// MAX_BEATS and never crossing a 4 KB page. Latency: first request valid the cycle after start_i.
// Backpressure: request held stable until stream_ready_i; at most MAX_OUTST bursts unfinished.
// Ports: clk/rstn; start_i/addr_i/len_i descriptor; active_i abort when low;
//        stream_* request channel (valid/addr/alen/size out, ready/finish in);
//        busy_o (not idle), done_o completion pulse, err_o misaligned-descriptor pulse.
module dma_burst_streamer
    import dma_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 32,
    parameter int DATA_BYTES = 8,
    parameter int MAX_BEATS  = 16,
    parameter int MAX_OUTST  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              active_i,
    output logic              stream_valid_o,
    output logic [ADDR_W-1:0] stream_addr_o,
    output logic [7:0]        stream_alen_o,
    output logic [2:0]        stream_size_o,
    input  logic              stream_ready_i,
    input  logic              stream_finish_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int SZ = $clog2(DATA_BYTES);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam logic [OW-1:0] L_MAX_OUTST = OW'(MAX_OUTST);

    e_streamer_st_t r_state;
    e_streamer_st_t w_state_nxt;

    logic [ADDR_W-1:0] r_cur_addr;
    logic [LEN_W-1:0]  r_rem_beats;
    logic [OW-1:0]     r_outst;
    logic              r_err;

    logic [LEN_W:0]    w_beats;
    logic [7:0]        w_alen;
    logic              w_misaligned;
    logic              w_accept;
    logic              w_abort;
    logic              w_hs;
    logic              w_fin;
    logic [LEN_W-1:0]  w_rem_nxt;
    logic [ADDR_W-1:0] w_step;

    dma_burst_calc #(
        .LEN_W      (LEN_W),
        .DATA_BYTES (DATA_BYTES),
        .MAX_BEATS  (MAX_BEATS)
    ) u_calc (
        .i_page_off  (r_cur_addr[11:0]),
        .i_rem_beats (r_rem_beats),
        .o_beats     (w_beats),
        .o_alen      (w_alen)
    );

    assign w_misaligned = ((addr_i & ADDR_W'(DATA_BYTES - 1)) != '0) ||
                          ((len_i  & LEN_W'(DATA_BYTES - 1))  != '0);
    assign w_accept     = (r_state == ST_IDLE) && start_i && !w_misaligned;
    assign w_abort      = (r_state != ST_IDLE) && !active_i;

    // active_i gates valid directly so an abort withdraws the request in the same cycle.
    assign stream_valid_o = (r_state == ST_ISSUE) && (r_outst < L_MAX_OUTST) && active_i;
    assign stream_addr_o  = r_cur_addr;
    // Outside ISSUE the calculator sees rem_beats==0 and would yield alen=0xFF; show 0 instead.
    assign stream_alen_o  = (r_state == ST_ISSUE) ? w_alen : 8'd0;
    assign stream_size_o  = 3'(SZ);

    assign w_hs      = stream_valid_o && stream_ready_i;
    // A finish with nothing outstanding is a stray and is dropped.
    assign w_fin     = stream_finish_i && (r_outst != '0);
    assign w_rem_nxt = r_rem_beats - LEN_W'(w_beats);
    assign w_step    = ADDR_W'(w_beats) << SZ;

    assign busy_o = (r_state != ST_IDLE);
    assign done_o = (r_state == ST_DONE) && active_i;
    assign err_o  = r_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (len_i == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_hs && (w_rem_nxt == '0)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((r_outst == '0) || ((r_outst == OW'(1)) && stream_finish_i)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cur_addr  <= '0;
            r_rem_beats <= '0;
            r_outst     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= (r_state == ST_IDLE) && start_i && w_misaligned;
            if (w_abort) begin
                r_cur_addr  <= '0;
                r_rem_beats <= '0;
                r_outst     <= '0;
            end else begin
                if (w_accept) begin
                    r_cur_addr  <= addr_i;
                    r_rem_beats <= len_i >> SZ;
                end else if (w_hs) begin
                    // Address wraps modulo 2^ADDR_W by plain truncation.
                    r_cur_addr  <= r_cur_addr + w_step;
                    r_rem_beats <= w_rem_nxt;
                end
                case ({w_hs, w_fin})
                    2'b10:   r_outst <= r_outst + OW'(1);
                    2'b01:   r_outst <= r_outst - OW'(1);
                    default: r_outst <= r_outst;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_burst_streamer.sv
module tb_dma_burst_streamer;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  alen;
    } burst_t;

    logic        clk;
    logic        rstn;
    logic        start_i;
    logic [31:0] addr_i;
    logic [31:0] len_i;
    logic        active_i;
    logic        stream_valid_o;
    logic [31:0] stream_addr_o;
    logic [7:0]  stream_alen_o;
    logic [2:0]  stream_size_o;
    logic        stream_ready_i;
    logic        stream_finish_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    dma_burst_streamer #(
        .ADDR_W     (32),
        .LEN_W      (32),
        .DATA_BYTES (8),
        .MAX_BEATS  (16),
        .MAX_OUTST  (4)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .start_i         (start_i),
        .addr_i          (addr_i),
        .len_i           (len_i),
        .active_i        (active_i),
        .stream_valid_o  (stream_valid_o),
        .stream_addr_o   (stream_addr_o),
        .stream_alen_o   (stream_alen_o),
        .stream_size_o   (stream_size_o),
        .stream_ready_i  (stream_ready_i),
        .stream_finish_i (stream_finish_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nbad = 0;

    // Model state: what the streamer must still issue and what it owes.
    burst_t m_q[$];
    int     m_outst    = 0;
    bit     m_busy     = 0;
    bit     m_done_cyc = 0;
    bit     m_err_cyc  = 0;

    // Observations of the DUT interface.
    burst_t hs_log[$];
    int     stall_cnt = 0;
    int     done_cnt  = 0;
    int     err_cnt   = 0;

    // Responder: finish each burst 3 cycles after its handshake when enabled.
    int fin_q[$];
    bit auto_fin = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic build_bursts(input logic [31:0] a0, input logic [31:0] len);
        logic [31:0] a;
        int r, b, pg;
        burst_t e;
        a = a0;
        r = int'(len / 8);
        while (r > 0) begin
            pg = (4096 - int'(a % 4096)) / 8;
            b  = r;
            if (b > 16) b = 16;
            if (b > pg) b = pg;
            e.addr = a;
            e.alen = 8'(b - 1);
            m_q.push_back(e);
            a = a + 32'(b * 8);
            r = r - b;
        end
    endtask

    // One clock cycle: compare against the model mid-cycle, advance the model, then step.
    task automatic tick();
        bit exp_valid, hs, fin, q_empty0, nxt_err;
        burst_t e;
        @(negedge clk);
        if (rstn) begin
            exp_valid = (m_q.size() > 0) && (m_outst < 4) && active_i;
            chk("valid", 64'(stream_valid_o), 64'(exp_valid));
            chk("busy",  64'(busy_o),  64'(m_busy));
            chk("done",  64'(done_o),  64'(m_done_cyc));
            chk("err",   64'(err_o),   64'(m_err_cyc));
            if (exp_valid) begin
                chk("req_addr", 64'(stream_addr_o), 64'(m_q[0].addr));
                chk("req_alen", 64'(stream_alen_o), 64'(m_q[0].alen));
            end
            if (stream_valid_o && stream_ready_i) begin
                e.addr = stream_addr_o;
                e.alen = stream_alen_o;
                hs_log.push_back(e);
                if (auto_fin) fin_q.push_back(cyc + 3);
            end
            if (stream_valid_o && !stream_ready_i) stall_cnt++;
            if (done_o) done_cnt++;
            if (err_o)  err_cnt++;

            hs       = exp_valid && stream_ready_i;
            fin      = stream_finish_i && (m_outst > 0);
            q_empty0 = (m_q.size() == 0);
            nxt_err  = 0;
            if (m_done_cyc) begin
                m_done_cyc = 0;
                m_busy     = 0;
            end else if (m_busy && !active_i) begin
                m_busy  = 0;
                m_outst = 0;
                m_q.delete();
            end else if (m_busy) begin
                if (hs) begin
                    void'(m_q.pop_front());
                    m_outst++;
                end
                if (fin) m_outst--;
                if (q_empty0 && m_outst == 0) m_done_cyc = 1;
            end else if (start_i) begin
                if ((addr_i % 8 != 0) || (len_i % 8 != 0)) begin
                    nxt_err = 1;
                end else if (len_i == 0) begin
                    m_busy     = 1;
                    m_done_cyc = 1;
                end else begin
                    build_bursts(addr_i, len_i);
                    m_busy = 1;
                end
            end
            m_err_cyc = nxt_err;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (auto_fin) begin
            stream_finish_i = 1'b0;
            while (fin_q.size() > 0 && fin_q[0] < cyc) void'(fin_q.pop_front());
            if (fin_q.size() > 0 && fin_q[0] == cyc) begin
                stream_finish_i = 1'b1;
                void'(fin_q.pop_front());
            end
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] l);
        addr_i  = a;
        len_i   = l;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_o && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_idle_timeout"}, 64'(busy_o), 64'(0));
        repeat (2) tick();
    endtask

    task automatic chk_hs(input string name, input int idx, input logic [31:0] a, input logic [7:0] al);
        if (idx < hs_log.size()) begin
            chk({name, "_addr"}, 64'(hs_log[idx].addr), 64'(a));
            chk({name, "_alen"}, 64'(hs_log[idx].alen), 64'(al));
        end else begin
            chk({name, "_missing"}, 64'(hs_log.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        int b, d0, e0, s0;
        rstn            = 1'b0;
        start_i         = 1'b0;
        addr_i          = '0;
        len_i           = '0;
        active_i        = 1'b1;
        stream_ready_i  = 1'b1;
        stream_finish_i = 1'b0;
        repeat (2) tick();
        chk("rst_valid", 64'(stream_valid_o), 64'(0));
        chk("rst_busy",  64'(busy_o),  64'(0));
        chk("rst_done",  64'(done_o),  64'(0));
        chk("rst_err",   64'(err_o),   64'(0));
        chk("rst_addr",  64'(stream_addr_o), 64'(0));
        chk("rst_alen",  64'(stream_alen_o), 64'(0));
        chk("rst_size",  64'(stream_size_o), 64'(3));
        rstn = 1'b1;
        repeat (2) tick();

        // Two full 16-beat bursts, finishes 3 cycles after each handshake.
        auto_fin = 1;
        b = hs_log.size(); d0 = done_cnt;
        start(32'h1000, 32'h100);
        wait_idle("t1");
        chk("t1_nreq", 64'(hs_log.size() - b), 64'(2));
        chk_hs("t1_req0", b,     32'h1000, 8'd15);
        chk_hs("t1_req1", b + 1, 32'h1080, 8'd15);
        chk("t1_done", 64'(done_cnt - d0), 64'(1));

        // Split at the 4 KB page boundary.
        b = hs_log.size();
        start(32'h0FF0, 32'h20);
        wait_idle("t2");
        chk("t2_nreq", 64'(hs_log.size() - b), 64'(2));
        chk_hs("t2_req0", b,     32'h0FF0, 8'd1);
        chk_hs("t2_req1", b + 1, 32'h1000, 8'd1);

        // Outstanding limit with finishes withheld.
        auto_fin = 0;
        stream_finish_i = 1'b0;
        b = hs_log.size(); d0 = done_cnt;
        start(32'h0, 32'h400);
        repeat (10) tick();
        chk("t3_nreq_at_limit", 64'(hs_log.size() - b), 64'(4));
        chk("t3_valid_at_limit", 64'(stream_valid_o), 64'(0));
        stream_finish_i = 1'b1;
        tick();
        stream_finish_i = 1'b0;
        repeat (3) tick();
        chk("t3_nreq_one_release", 64'(hs_log.size() - b), 64'(5));
        chk("t3_valid_relimit", 64'(stream_valid_o), 64'(0));
        stream_finish_i = 1'b1;
        wait_idle("t3");
        stream_finish_i = 1'b0;
        chk("t3_nreq_total", 64'(hs_log.size() - b), 64'(8));
        chk("t3_done", 64'(done_cnt - d0), 64'(1));

        // Backpressure on the first request for 5 cycles.
        auto_fin = 1;
        stream_ready_i = 1'b0;
        b = hs_log.size(); s0 = stall_cnt;
        start(32'h2000, 32'h100);
        repeat (5) tick();
        chk("t4_stall_cycles", 64'(stall_cnt - s0), 64'(5));
        chk("t4_no_hs", 64'(hs_log.size() - b), 64'(0));
        stream_ready_i = 1'b1;
        repeat (2) tick();
        chk_hs("t4_req0", b,     32'h2000, 8'd15);
        chk_hs("t4_req1", b + 1, 32'h2080, 8'd15);
        wait_idle("t4");

        // Abort after two of eight bursts, then a clean restart.
        auto_fin = 0;
        stream_finish_i = 1'b0;
        b = hs_log.size(); d0 = done_cnt;
        start(32'h3000, 32'h400);
        repeat (2) tick();
        active_i = 1'b0;
        #1;
        chk("t5_valid_drop", 64'(stream_valid_o), 64'(0));
        chk("t5_busy_before", 64'(busy_o), 64'(1));
        tick();
        chk("t5_busy_after", 64'(busy_o), 64'(0));
        active_i = 1'b1;
        repeat (3) tick();
        chk("t5_nreq", 64'(hs_log.size() - b), 64'(2));
        chk("t5_no_done", 64'(done_cnt - d0), 64'(0));
        auto_fin = 1;
        b = hs_log.size(); d0 = done_cnt;
        start(32'h1000, 32'h100);
        wait_idle("t5b");
        chk_hs("t5b_req0", b,     32'h1000, 8'd15);
        chk_hs("t5b_req1", b + 1, 32'h1080, 8'd15);
        chk("t5b_done", 64'(done_cnt - d0), 64'(1));

        // Misaligned descriptors and zero length.
        b = hs_log.size(); e0 = err_cnt; d0 = done_cnt;
        start(32'h1004, 32'h100);
        repeat (3) tick();
        chk("t6_err_addr", 64'(err_cnt - e0), 64'(1));
        start(32'h1000, 32'h104);
        repeat (3) tick();
        chk("t6_err_len", 64'(err_cnt - e0), 64'(2));
        start(32'h1000, 32'h0);
        repeat (3) tick();
        chk("t6_len0_done", 64'(done_cnt - d0), 64'(1));
        chk("t6_no_req", 64'(hs_log.size() - b), 64'(0));

        // Address wrap at the top of the address space.
        b = hs_log.size();
        start(32'hFFFF_FF80, 32'h100);
        wait_idle("t7");
        chk_hs("t7_req0", b,     32'hFFFF_FF80, 8'd15);
        chk_hs("t7_req1", b + 1, 32'h0000_0000, 8'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
